// File: rtl/reg_file_2w2r.sv
// Y86 register file: NREG x DATA_W storage, two combinational read ports, two write ports (M beats E)
// and a one-register-per-cycle soft-clear sweep. Define REGFILE_BYPASS_EN to forward same-cycle writes.
module reg_file_2w2r #(
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          NREG      = 8,
   parameter int unsigned          ADDR_W    = 3,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0,
   parameter int unsigned          SP_IDX    = 4,
   parameter logic [DATA_W-1:0]    SP_RESET  = DATA_W'(32'h0000_0400)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] srcA,
   output logic [DATA_W-1:0] valA,
   input  logic [ADDR_W-1:0] srcB,
   output logic [DATA_W-1:0] valB,
   input  logic              weE,
   input  logic [ADDR_W-1:0] dstE,
   input  logic [DATA_W-1:0] valE,
   input  logic              weM,
   input  logic [ADDR_W-1:0] dstM,
   input  logic [DATA_W-1:0] valM,
   input  logic              clr_req,
   output logic              clr_busy
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   regs_d [NREG];
   logic                we_e, we_m;

   function automatic logic [DATA_W-1:0] reset_value(input int unsigned idx);
      return (idx == SP_IDX) ? SP_RESET : RESET_VAL;
   endfunction

   // Writes land only while idle and only for existing registers.
   assign we_e = weE && (32'(dstE) < NREG) && (state_q == ST_IDLE);
   assign we_m = weM && (32'(dstM) < NREG) && (state_q == ST_IDLE);

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // NOTE: combinational blocks assign defaults first so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == ADDR_W'(NREG - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      clr_busy = (state_q == ST_CLEAR);
   end

   // ---------------- storage ----------------
   always_comb begin
      regs_d = regs_q;
      if (state_q == ST_CLEAR) begin
         regs_d[cnt_q] = reset_value(32'(cnt_q));
      end else begin
         if (we_e) regs_d[dstE] = valE;
         // M is applied last so it overrides E on a shared destination (popl %esp).
         if (we_m) regs_d[dstM] = valM;
      end
   end

   // NOTE: the storage array is reset on purpose; architectural reset values (e.g. %esp) are required.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[ADDR_W'(i)] <= reset_value(i);
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // ---------------- read ports ----------------
   always_comb begin
      valA = '0;
      if (32'(srcA) < NREG) valA = regs_q[srcA];
`ifdef REGFILE_BYPASS_EN
      if (we_e && (srcA == dstE)) valA = valE;
      if (we_m && (srcA == dstM)) valA = valM;
`endif
   end

   always_comb begin
      valB = '0;
      if (32'(srcB) < NREG) valB = regs_q[srcB];
`ifdef REGFILE_BYPASS_EN
      if (we_e && (srcB == dstE)) valB = valE;
      if (we_m && (srcB == dstM)) valB = valM;
`endif
   end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r: an 8-register instance and a 6-register instance (ADDR_W=3).
// Expected values are hand-computed; the REGFILE_BYPASS_EN build changes the write-cycle read expectation.
module tb_reg_file_2w2r;

   logic        clk = 1'b0;
   logic        reset_n;

   logic [2:0]  srcA, srcB, dstE, dstM;
   logic [31:0] valA, valB, valE, valM;
   logic        weE, weM, clr_req, clr_busy;

   logic [2:0]  srcA_6, srcB_6, dstE_6, dstM_6;
   logic [31:0] valA_6, valB_6, valE_6, valM_6;
   logic        weE_6, weM_6, clr_req_6, clr_busy_6;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reg_file_2w2r u_dut (
      .clk(clk), .reset_n(reset_n),
      .srcA(srcA), .valA(valA), .srcB(srcB), .valB(valB),
      .weE(weE), .dstE(dstE), .valE(valE),
      .weM(weM), .dstM(dstM), .valM(valM),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   reg_file_2w2r #(.NREG(6), .ADDR_W(3)) u_dut6 (
      .clk(clk), .reset_n(reset_n),
      .srcA(srcA_6), .valA(valA_6), .srcB(srcB_6), .valB(valB_6),
      .weE(weE_6), .dstE(dstE_6), .valE(valE_6),
      .weM(weM_6), .dstM(dstM_6), .valM(valM_6),
      .clr_req(clr_req_6), .clr_busy(clr_busy_6)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [31:0] exp_wc;

      reset_n = 1'b0;
      srcA = '0; srcB = '0; weE = 1'b0; dstE = '0; valE = '0;
      weM = 1'b0; dstM = '0; valM = '0; clr_req = 1'b0;
      srcA_6 = '0; srcB_6 = '0; weE_6 = 1'b0; dstE_6 = '0; valE_6 = '0;
      weM_6 = 1'b0; dstM_6 = '0; valM_6 = '0; clr_req_6 = 1'b0;

      // 1. reset contents
      #12;
      reset_n = 1'b1;
      @(negedge clk);
      srcA = 3'd4;
      #1 check("reset_sp", valA, 32'h0000_0400);
      check("reset_busy", 32'(clr_busy), 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (i != 4) begin
            @(negedge clk);
            srcB = 3'(i);
            #1 check($sformatf("reset_r%0d", i), valB, 32'd0);
         end
      end

      // 2. dual write to distinct registers
      @(negedge clk);
      weE = 1'b1; dstE = 3'd1; valE = 32'd11;
      weM = 1'b1; dstM = 3'd2; valM = 32'd22;
      tick();
      weE = 1'b0; weM = 1'b0;
      srcA = 3'd1; srcB = 3'd2;
      #1 check("dual_a_r1", valA, 32'd11);
      check("dual_b_r2", valB, 32'd22);

      // 3. same destination: M wins
      @(negedge clk);
      weE = 1'b1; dstE = 3'd3; valE = 32'd5;
      weM = 1'b1; dstM = 3'd3; valM = 32'd9;
      srcA = 3'd3;
`ifdef REGFILE_BYPASS_EN
      exp_wc = 32'd9;
`else
      exp_wc = 32'd0;
`endif
      #1 check("conflict_write_cycle", valA, exp_wc);
      tick();
      weE = 1'b0; weM = 1'b0;
      #1 check("conflict_r3", valA, 32'd9);
      check("conflict_r2_kept", valB, 32'd22);

      // 4. fill with pattern, then sweep
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         weE = 1'b1; dstE = 3'(i); valE = 32'hA5A5_A5A5;
         tick();
         weE = 1'b0;
      end
      @(negedge clk);
      srcA = 3'd7; srcB = 3'd4;
      #1 check("fill_r7", valA, 32'hA5A5_A5A5);
      check("fill_r4", valB, 32'hA5A5_A5A5);
      @(negedge clk);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      check("clear_busy_start", 32'(clr_busy), 32'd1);
      n = 0;
      while (clr_busy === 1'b1 && n < 20) begin
         n++;
         if (n == 3) begin
            srcA = 3'd1; srcB = 3'd5;
            #1 check("sweep_partial_r1", valA, 32'd0);
            check("sweep_partial_r5", valB, 32'hA5A5_A5A5);
         end
         if (n == 4) begin
            weE = 1'b1; dstE = 3'd0; valE = 32'h0000_1234;
         end else begin
            weE = 1'b0;
         end
         tick();
      end
      weE = 1'b0;
      check("clear_busy_cycles", 32'(n), 32'd8);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         srcA = 3'(i);
         #1 check($sformatf("after_clear_r%0d", i), valA, (i == 4) ? 32'h0000_0400 : 32'd0);
      end

      // 5. reset in the middle of a sweep
      @(negedge clk);
      weE = 1'b1; dstE = 3'd1; valE = 32'hA5A5_A5A5;
      weM = 1'b1; dstM = 3'd5; valM = 32'hA5A5_A5A5;
      tick();
      dstE = 3'd4; weM = 1'b0;
      tick();
      weE = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      srcA = 3'd5; srcB = 3'd4;
      #1 check("midsweep_busy_before", 32'(clr_busy), 32'd1);
      check("midsweep_r5_before", valA, 32'hA5A5_A5A5);
      #1 reset_n = 1'b0;
      #1 check("midsweep_busy_dropped", 32'(clr_busy), 32'd0);
      check("midsweep_r5_reset", valA, 32'd0);
      check("midsweep_r4_reset", valB, 32'h0000_0400);
      srcA = 3'd1;
      #1 check("midsweep_r1_reset", valA, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("midsweep_busy_after", 32'(clr_busy), 32'd0);

      // 6. six-register instance: out-of-range write dropped, 6-cycle sweep
      @(negedge clk);
      weE_6 = 1'b1; dstE_6 = 3'd7; valE_6 = 32'h77;
      weM_6 = 1'b1; dstM_6 = 3'd5; valM_6 = 32'h55;
      tick();
      weE_6 = 1'b0; weM_6 = 1'b0;
      srcA_6 = 3'd7; srcB_6 = 3'd5;
      #1 check("n6_r7_dropped", valA_6, 32'd0);
      check("n6_r5_written", valB_6, 32'h55);
      srcA_6 = 3'd6;
      #1 check("n6_r6_reads0", valA_6, 32'd0);
      @(negedge clk);
      clr_req_6 = 1'b1;
      tick();
      clr_req_6 = 1'b0;
      n = 0;
      while (clr_busy_6 === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      check("n6_busy_cycles", 32'(n), 32'd6);
      srcA_6 = 3'd4; srcB_6 = 3'd5;
      #1 check("n6_after_r4", valA_6, 32'h0000_0400);
      check("n6_after_r5", valB_6, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
